// File: rtl/fpu_pkg.sv
// fpu_pkg: shared fp32 definitions for the FPU datapath blocks.
//   FP32_EXP_W / FP32_MAN_W / FP32_BIAS : fp32 field widths and exponent bias
//   fp_class_t      : operand class (ZERO, DENORM, NORMAL, INF, NAN)
//   fp32_unpacked_t : sign, biased exponent, mantissa and class of an operand
//   fp32_unpack()   : splits a raw fp32 word into fp32_unpacked_t
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
    fp_class_t             cls;
  } fp32_unpacked_t;

  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.man  = x[22:0];
    if (u.exp == '1) begin
      u.cls = (u.man != '0) ? NAN : INF;
    end else if (u.exp == '0) begin
      u.cls = (u.man != '0) ? DENORM : ZERO;
    end else begin
      u.cls = NORMAL;
    end
    return u;
  endfunction

endpackage

// File: rtl/fpu_f2i_round.sv
// fpu_f2i_round: combinational shift / round / saturate / negate for fpu_f2i.
//   op        in   unpacked fp32 operand (from the stage-1 register)
//   result    out  OUT_W-bit two's-complement integer
//   exception out  NaN, infinity or out-of-range; result saturated
//   inexact   out  nonzero fraction bits were discarded
// Optional feature: define FPU_F2I_RNE_EN for round-to-nearest-even;
// otherwise the conversion truncates toward zero.
module fpu_f2i_round
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  fp32_unpacked_t   op,
  output logic [OUT_W-1:0] result,
  output logic             exception,
  output logic             inexact
);

  // Magnitude limits for each sign; the negative side reaches one further.
  localparam logic [33:0] MAX_MAG = (34'd1 << (OUT_W-1)) - 34'd1;
  localparam logic [33:0] MIN_MAG = 34'd1 << (OUT_W-1);
  localparam logic [OUT_W-1:0] MAX_RES = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_RES = {1'b1, {(OUT_W-1){1'b0}}};

  logic [4:0]  shamt;
  logic [55:0] wide;      // {1,m} as fixed point, 23 fraction bits, shifted by e
  logic [32:0] int_part;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [33:0] mag;
  logic        huge;
  logic        ovf;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case/if leaves it unassigned (which would infer a latch).
    result    = '0;
    exception = 1'b0;
    inexact   = 1'b0;

    // Only meaningful for 0 <= e <= 31; larger exponents are caught by huge.
    shamt = 5'(op.exp - 8'(FP32_BIAS));
    wide  = {32'd0, 1'b1, op.man} << shamt;

    if (op.exp < 8'(FP32_BIAS)) begin
      // e < 0: integer part is 0. At e = -1 the hidden bit is the guard bit;
      // below that everything is sticky (the hidden bit alone is nonzero).
      int_part = '0;
      guard    = (op.exp == 8'(FP32_BIAS-1));
      sticky   = (op.exp != 8'(FP32_BIAS-1)) | (op.man != '0);
    end else begin
      int_part = wide[55:23];
      guard    = wide[22];
      sticky   = |wide[21:0];
    end

`ifdef FPU_F2I_RNE_EN
    round_up = guard & (sticky | int_part[0]);
`else
    round_up = 1'b0;
`endif

    mag  = {1'b0, int_part} + {33'd0, round_up};
    huge = (op.exp >= 8'(FP32_BIAS + 32));
    ovf  = huge | (op.sign ? (mag > MIN_MAG) : (mag > MAX_MAG));

    unique case (op.cls)
      NAN: begin
        exception = 1'b1;
      end
      INF: begin
        exception = 1'b1;
        result    = op.sign ? MIN_RES : MAX_RES;
      end
      ZERO: begin
        result = '0;
      end
      default: begin
        // NORMAL and DENORM; a denormal lands in the e < 0 path and yields 0.
        if (ovf) begin
          exception = 1'b1;
          result    = op.sign ? MIN_RES : MAX_RES;
        end else begin
          result  = op.sign ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
          inexact = guard | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fpu_f2i.sv
// fpu_f2i: two-stage pipelined fp32 -> signed OUT_W-bit integer converter.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   a holds a valid operand
//   in_ready  out  converter accepts a this cycle
//   a         in   fp32 operand
//   out_valid out  result / flags valid
//   out_ready in   consumer accepts the result this cycle
//   result    out  signed integer (saturated on exception)
//   exception out  NaN, infinity or out-of-range input
//   inexact   out  nonzero fraction bits discarded
// Stage 1 registers the unpacked operand, stage 2 registers the converted
// result. Both stages stall without bubbles under backpressure.
// Optional feature: FPU_F2I_RNE_EN selects round-to-nearest-even.
module fpu_f2i
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             exception,
  output logic             inexact
);

  // run_q keeps in_ready low during reset and for the cycle it is released.
  logic           run_q, run_d;
  logic           s1_valid_q, s1_valid_d;
  fp32_unpacked_t s1_op_q, s1_op_d;
  logic           s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic           exception_q, exception_d;
  logic           inexact_q, inexact_d;

  logic             s2_adv;
  logic             s2_load;
  logic             in_fire;
  logic [OUT_W-1:0] rnd_result;
  logic             rnd_exception;
  logic             rnd_inexact;

  fpu_f2i_round #(
    .OUT_W (OUT_W)
  ) u_round (
    .op        (s1_op_q),
    .result    (rnd_result),
    .exception (rnd_exception),
    .inexact   (rnd_inexact)
  );

  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    in_ready = run_q & (~s1_valid_q | s2_adv);
    in_fire  = in_valid & in_ready;
    s2_load  = s2_adv & s1_valid_q;

    run_d      = 1'b1;
    // Stage 1 stays full if it is blocked, or refills from a new transfer.
    s1_valid_d = (s1_valid_q & ~s2_adv) | in_fire;
    s1_op_d    = in_fire ? fp32_unpack(a) : s1_op_q;

    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    result_d    = s2_load ? rnd_result    : result_q;
    exception_d = s2_load ? rnd_exception : exception_q;
    inexact_d   = s2_load ? rnd_inexact   : inexact_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the valid bits because
      // result and flags must read 0 while rst is high.
      run_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      exception_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values and the two stages shift together.
      run_q       <= run_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      exception_q <= exception_d;
      inexact_q   <= inexact_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign exception = exception_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fpu_f2i.sv
// tb_fpu_f2i: scoreboard bench for fpu_f2i (OUT_W = 32). Stimulus pushes the
// expected response into a queue on every input transfer; an independent
// monitor pops and compares on every output transfer. Random operands are
// scored against a division-based reference model. Build with
// FPU_F2I_RNE_EN defined to check the round-to-nearest-even variant.
module tb_fpu_f2i;

  localparam int OUT_W = 32;
  localparam longint MAXV = (longint'(1) << (OUT_W-1)) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exception;
  logic        inexact;

  always #5 clk = ~clk;

  fpu_f2i #(
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception),
    .inexact   (inexact)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    logic        exc;
    logic        inx;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Value = {1,m} * 2^(e-23); integer quotient and remainder by plain division.
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] r,
                                    output logic exc, output logic inx);
    int     ex;
    longint sig, q, rem, den;
    exc = 1'b0;
    inx = 1'b0;
    r   = '0;
    if (x[30:23] == 8'hff) begin
      exc = 1'b1;
      if (x[22:0] == 0) r = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
      return;
    end
    if (x[30:23] == 8'h00) begin
      inx = (x[22:0] != 0);
      return;
    end
    ex  = int'(x[30:23]) - 127;
    sig = longint'(x[22:0]) + (longint'(1) << 23);
    if (ex > 40) begin
      q = MAXV + 2; rem = 0; den = 1;
    end else if (ex >= 23) begin
      q = sig << (ex - 23); rem = 0; den = 1;
    end else if (ex >= -30) begin
      den = longint'(1) << (23 - ex);
      q   = sig / den;
      rem = sig % den;
    end else begin
      q = 0; rem = 1; den = longint'(1) << 60;
    end
`ifdef FPU_F2I_RNE_EN
    if ((2 * rem > den) || ((2 * rem == den) && q[0])) q = q + 1;
`endif
    if ((!x[31] && q > MAXV) || (x[31] && q > MAXV + 1)) begin
      exc = 1'b1;
      r   = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
      return;
    end
    inx = (rem != 0);
    r   = x[31] ? 32'(-q) : 32'(q);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 9))
      0:       e = 8'hff;
      1:       e = 8'h00;
      2:       e = 8'($urandom_range(120, 130));
      default: e = 8'($urandom_range(110, 165));
    endcase
    m = 23'($urandom);
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // Drive one operand, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [31:0] x, input logic [31:0] r, input logic e,
                      input logic i, input bit lat);
    exp_t it;
    int   budget;
    budget   = 0;
    in_valid = 1'b1;
    a        = x;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout a=%08h: in_ready stayed 0, required 1", x);
    end else begin
      it.a   = x;
      it.res = r;
      it.exc = e;
      it.inx = i;
      it.cyc = cyc;
      it.lat = lat;
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] x);
    logic [31:0] r;
    logic        e, i;
    ref_model(x, r, e, i);
    send(x, r, e, i, 1'b0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: scores every output transfer and checks outputs hold while stalled.
  logic [31:0] hold_res;
  logic        hold_exc, hold_inx;
  bit          stalled = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t it;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_result", result, hold_res);
        check("hold_exception", exception, hold_exc);
        check("hold_inexact", inexact, hold_inx);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
        end else begin
          it = exp_q.pop_front();
          check($sformatf("result a=%08h", it.a), result, it.res);
          check($sformatf("exception a=%08h", it.a), exception, it.exc);
          check($sformatf("inexact a=%08h", it.a), inexact, it.inx);
          if (it.lat) check($sformatf("latency a=%08h", it.a), cyc - it.cyc, 2);
        end
      end
      stalled  = out_valid && !out_ready;
      hold_res = result;
      hold_exc = exception;
      hold_inx = inexact;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    bit  rdone;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_result", result, 0);
    check("reset_exception", exception, 0);
    check("reset_inexact", inexact, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, back-to-back, no stall, latency checked.
    send(32'h3f80_0000, 32'd1,          0, 0, 1);
    send(32'h4040_0000, 32'd3,          0, 0, 1);
    send(32'hbf80_0000, 32'hffff_ffff,  0, 0, 1);
    send(32'h7f80_0000, 32'h7fff_ffff,  1, 0, 1);
    send(32'hff80_0000, 32'h8000_0000,  1, 0, 1);
    send(32'h7fc0_0000, 32'd0,          1, 0, 1);
    send(32'hcf00_0000, 32'h8000_0000,  0, 0, 1);
    send(32'h4f00_0000, 32'h7fff_ffff,  1, 0, 1);
    send(32'hcf00_0001, 32'h8000_0000,  1, 0, 1);
    send(32'h0000_0000, 32'd0,          0, 0, 1);
    send(32'h8000_0000, 32'd0,          0, 0, 1);
    send(32'h0000_0001, 32'd0,          0, 1, 1);
    send(32'h4020_0000, 32'd2,          0, 1, 1);
    send(32'h3f00_0000, 32'd0,          0, 1, 1);
`ifdef FPU_F2I_RNE_EN
    send(32'h4060_0000, 32'd4,          0, 1, 1);
    send(32'h3f40_0000, 32'd1,          0, 1, 1);
    send(32'hc060_0000, 32'hffff_fffc,  0, 1, 1);
    send(32'h3fc0_0000, 32'd2,          0, 1, 1);
`else
    send(32'h4060_0000, 32'd3,          0, 1, 1);
    send(32'h3f40_0000, 32'd0,          0, 1, 1);
    send(32'hc060_0000, 32'hffff_fffd,  0, 1, 1);
    send(32'h3fc0_0000, 32'd1,          0, 1, 1);
`endif
    drain();

    // Backpressure: out_ready low for 4 cycles while streaming 1.0, 2.0, 3.0.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h3f80_0000, 32'd1, 0, 0, 0);
    send(32'h4000_0000, 32'd2, 0, 0, 0);
    in_valid = 1'b1;
    a        = 32'h4040_0000;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h4040_0000, 32'd3, 0, 0, 0);
    drain();

    // Reset with both stages full: nothing stale may come out afterwards.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h4000_0000, 32'd2, 0, 0, 0);
    send(32'h4080_0000, 32'd4, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_rise", in_ready, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_stale_output", seen, 0);

    // Random operands with random backpressure.
    @(posedge clk);
    #1;
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_model(rand_fp());
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_f2i.md
# fpu_f2i

Pipelined IEEE-754 single-precision to signed-integer converter: decodes the fp32 encoding produced and consumed by `fpu_add` back into a two's-complement integer. Sits downstream of the FPU datapath, feeding integer consumers such as DSP index/gain logic and the test monitors. Two-stage pipeline with valid/ready handshakes on both sides. Sustains one conversion per cycle.

## Interface

Parameters:
- `OUT_W`, 32: result integer width; legal range 8..32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `a` holds a valid operand.
- `in_ready`  out  1  converter can accept `a` this cycle.
- `a`  in  32  fp32 operand.
- `out_valid`  out  1  `result`/flags are valid.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `result`  out  OUT_W  signed integer.
- `exception`  out  1  NaN, infinity or out-of-range input; `result` saturated.
- `inexact`  out  1  nonzero fraction bits were discarded.

## Operation

- Transfer occurs when valid and ready are both high in the same cycle.
- Stage 1 unpacks: sign `s`, exponent `E`, mantissa `m`, unbiased exponent `e = E - 127`. Inputs are classified as zero, denormal, normal, infinity or NaN.
- Stage 2 shifts, rounds, saturates and negates, then registers the outputs.
- Rules, with MAX = 2^(OUT_W-1)-1 and MIN = -2^(OUT_W-1):
  - NaN (`E`=255, `m`≠0): result 0, exception=1.
  - +inf: result MAX, exception=1. -inf: result MIN, exception=1.
  - Zero (±0): result 0, no flags.
  - Denormal: result 0, inexact=1.
  - `e` < 0: magnitude 0 before rounding, inexact=1.
  - `e` ≥ 23: magnitude = {1,m} << (e-23), exact.
  - 0 ≤ `e` < 23: magnitude = {1,m} >> (23-e). inexact=1 if any shifted-out bit is 1.
  - Overflow: magnitude > MAX with s=0, or > 2^(OUT_W-1) with s=1. Result saturates to MAX/MIN, exception=1, inexact=0.
  - Exactly MIN (s=1, e=OUT_W-1, m=0) is legal: result MIN, no flags.
  - Final result = s ? -magnitude : magnitude.
- Flags are mutually exclusive; exception has priority over inexact.

## Timing

- Latency: 2 cycles from input transfer to `out_valid` when not stalled.
- Throughput: 1 per cycle while `out_ready`=1.
- Pipeline is stallable with no bubbles:
  - Stage 2 holds when `out_valid`=1 and `out_ready`=0.
  - Stage 1 advances if stage 2 is empty or advancing.
  - `in_ready` = stage 1 empty or stage 1 advancing (combinational from stage state and `out_ready`).
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.
- Reset values while `rst`=1: all valid bits 0, `out_valid`=0, `result`=0, `exception`=0, `inexact`=0, `in_ready`=0.
- `in_ready` rises the first cycle after `rst` deasserts.
- Reset mid-operation discards both stages immediately; no partial result is emitted.
- Simultaneous output accept and input accept with a full pipeline: all three items are preserved in order.

## Configuration

- `FPU_F2I_RNE_EN` defined: round-to-nearest-even, using guard bit = first discarded bit and sticky = OR of the rest.
  - Increment magnitude when guard & (sticky | lsb).
  - The `e` = -1 case rounds via guard = hidden bit.
  - A rounding carry into overflow saturates with exception=1.
  - inexact is still set whenever discarded bits are nonzero.
- Undefined: truncation toward zero, as specified in Operation.

## Structure

- Shared package `fpu_pkg` holds:
  - `FP32_EXP_W`=8, `FP32_MAN_W`=23, `FP32_BIAS`=127.
  - Enum `fp_class_t` {ZERO, DENORM, NORMAL, INF, NAN}.
  - Struct `fp32_unpacked_t` {sign, exp, man, cls}.
- One sub-module, `fpu_f2i_round`: combinational stage-2 shift/round/saturate. The top level owns the pipeline registers and handshakes.

## Test plan

- Default build (truncation), OUT_W=32, `out_ready`=1:
  - 0x3f800000 → 1; 0x40400000 → 3; 0xbf800000 → 0xFFFFFFFF; all flags 0; each result 2 cycles after its input.
  - 0x7f800000 → 0x7FFFFFFF, exception=1. 0xff800000 → 0x80000000, exception=1. 0x7fc00000 → 0, exception=1.
  - 0xcf000000 (-2^31) → 0x80000000, no flags. 0x4f000000 (2^31) → 0x7FFFFFFF, exception=1.
  - 0x40600000 (3.5) → 3, inexact=1. 0x40200000 (2.5) → 2, inexact=1. 0x3f000000 (0.5) → 0, inexact=1.
- `FPU_F2I_RNE_EN` build, same inputs:
  - 3.5 → 4; 2.5 → 2; 0.5 → 0; 0x3f400000 (0.75) → 1; all inexact=1.
- Backpressure:
  - Stream 1.0, 2.0, 3.0 back-to-back with `out_ready`=0 for 4 cycles. `in_ready` drops after 2 accepts.
  - After release, outputs are 1, 2, 3 in order, no loss or duplication.
- Assert `rst` for 1 cycle with both stages full: `out_valid`=0 immediately, and no stale result appears afterwards.
